calc_engine: RTL and testbench
==============================

Name: calc_engine

Overview:
Consumer end of the keypad decoder interface. Takes one-cycle key strobes (digit / operator / equals), builds decimal operands, runs the arithmetic and presents the value to show on the display. Sits between the keypad decoder and the display driver. Multiplication uses a multi-cycle shift-add sub-unit.

Parameters:
MAX_DIGITS, 3, max decimal digits per entered operand (values 0..999)
OPW, 10, entered-operand width in bits; must satisfy OPW >= ceil(log2(10^MAX_DIGITS))
RES_W, 24, signed accumulator/result width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state immediately
btn_pressed  in  1  one-cycle key strobe from the decoder
is_num  in  1  key is a digit (qualified by btn_pressed)
is_op  in  1  key is an operator
is_eq  in  1  key is equals
num_val  in  4  digit value 0..9
op_val  in  2  operator: 00 add, 01 sub, 10 mul, 11 clear
disp_val  out  RES_W  signed value to display (current entry or last result)
op_pending  out  2  stored operator (valid when op_valid=1)
op_valid  out  1  an operator is stored and awaiting operand B
busy  out  1  computation in progress
result_valid  out  1  one-cycle pulse when a new result is loaded into disp_val
err  out  1  sticky overflow flag

Behaviour:
- Reset (async, active-low; 0 = reset): all outputs 0; state S_A; A, B and digit counts = 0. Reset asserted mid-multiply aborts the operation.
- Decoding: a key is acted on only when btn_pressed=1. Flag priority: is_num > is_op > is_eq. A strobe with no flag set is ignored. num_val > 9 is ignored.
- Clear (is_op with op_val=11): from any state including S_ERR and S_CALC, next cycle equals reset values.
- Digit append: val = val*10 + d, only if digit count < MAX_DIGITS; otherwise the key is ignored. A 0 pressed while val=0 leaves count at 0 (no leading zeros).
- States:
  - S_A: num -> append to A, disp_val = A. op -> store op, op_valid=1, go to S_OP. eq -> ignored.
  - S_OP: num -> B = d, go to S_B, disp_val = B. op -> replace the stored op. eq -> ignored.
  - S_B: num -> append to B. eq -> go to S_CALC (final). op -> go to S_CALC (chained); the new op is latched and applied afterwards.
  - S_CALC: busy=1; all keys except clear are dropped.
    - add/sub: result registered one cycle after entry.
    - mul: handled by the sub-unit, OPW cycles plus 1 cycle load.
    - On completion: disp_val = result, A = result, result_valid pulses, busy=0, B count cleared.
    - Final: go to S_RES, op_valid=0.
    - Chained: go to S_OP with the latched op.
  - S_RES: num -> A = d (new calculation), go to S_A. op -> store op, go to S_OP (A keeps the result). eq -> ignored.
  - S_ERR: entered when a result is outside the signed RES_W range. err=1, disp_val holds its last valid value, busy=0. Only clear exits.
- Latency, eq strobe at cycle N:
  - busy=1 from N+1.
  - add/sub: result_valid=1 and disp_val updated at N+2.
  - mul: result_valid=1 at N+OPW+2.
- Arithmetic: A is signed RES_W; B is unsigned OPW, zero-extended. Subtraction may go negative. Overflow is checked on the full-width intermediate: RES_W+1 bits for add/sub, RES_W+OPW bits for mul.

Decomposition:
- calc_pkg: op codes (OP_ADD, OP_SUB, OP_MUL, OP_CLR), state encoding (S_A, S_OP, S_B, S_CALC, S_RES, S_ERR), default widths.
- One sub-module, calc_mul_seq: signed RES_W × unsigned OPW shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done pulse, product of width RES_W+OPW.
  - Takes OPW cycles after start.

Test Plan:
- Keys 6, +, 1, = -> disp_val 6, then 1, then 7 at eq+2; result_valid pulses once; op_valid=0 afterwards.
- Keys 1,2,*,3,4,= -> busy high for OPW+1 cycles; disp_val=408 at eq+OPW+2.
- Keys 5,-,9,= -> disp_val = -4 (all ones in the upper bits); then key 3 -> disp_val 3, state S_A.
- Chained 2,+,3,*,4,= -> disp_val 5 after '*', then 20. Keys 1,2,3,4 -> 123 (fourth digit ignored). 0,0,7 -> 7.
- Overflow 999,*,999,*,999,= -> 998001 shown, then err=1 with disp_val held at 998001; digits ignored; clear -> all outputs 0.
- Assert reset low mid-multiply (during busy) -> outputs 0 immediately, without waiting for a clock edge; the next multiply computes correctly. A strobe with no flag set, or a key during busy -> no state change.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - operator codes, FSM states and default widths for the calculator engine
package calc_pkg;

  localparam int MAX_DIGITS_D = 3;
  localparam int OPW_D        = 10;
  localparam int RES_W_D      = 24;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/calc_if.sv
// rtl/calc_if.sv - keypad strobe inputs and display-side outputs of the calculator engine
interface calc_if
  import calc_pkg::*;
#(
  parameter int RES_W = RES_W_D
);

  logic             btn_pressed;
  logic             is_num;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic [RES_W-1:0] disp_val;
  logic [1:0]       op_pending;
  logic             op_valid;
  logic             busy;
  logic             result_valid;
  logic             err;

  modport master (
    output btn_pressed, is_num, is_op, is_eq, num_val, op_val,
    input  disp_val, op_pending, op_valid, busy, result_valid, err
  );

  modport slave (
    input  btn_pressed, is_num, is_op, is_eq, num_val, op_val,
    output disp_val, op_pending, op_valid, busy, result_valid, err
  );

endinterface

// File: rtl/calc_mul_seq.sv
// rtl/calc_mul_seq.sv - signed x unsigned shift-add multiplier, OPW iterations after start
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int RES_W = RES_W_D,
  parameter int OPW   = OPW_D
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [RES_W-1:0]      a,
  input  logic [OPW-1:0]        b,
  output logic                  done,
  output logic [RES_W+OPW-1:0]  product
);

  localparam int PW = RES_W + OPW;
  localparam int CW = $clog2(OPW + 1);

  logic [PW-1:0]  acc;
  logic [PW-1:0]  mcand;
  logic [OPW-1:0] mplier;
  logic [CW-1:0]  cnt;
  logic           running;

  // Multiplicand is sign-extended once; the multiplier is consumed LSB first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{OPW{a[RES_W-1]}}, a};
      mplier  <= b;
      cnt     <= '0;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(OPW - 1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/calc_engine.sv
// rtl/calc_engine.sv - keypad-driven calculator: operand entry, add/sub/mul, display value
module calc_engine
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_D,
  parameter int OPW        = OPW_D,
  parameter int RES_W      = RES_W_D
) (
  input  logic  clk,
  input  logic  reset,
  calc_if.slave bus
);

  localparam int CNTW = $clog2(MAX_DIGITS + 1);
  localparam int PW   = RES_W + OPW;

  state_e           state_q, state_n;
  logic [RES_W-1:0] a_q, a_n;
  logic [RES_W-1:0] disp_q, disp_n;
  logic [OPW-1:0]   b_q, b_n;
  logic [CNTW-1:0]  a_cnt_q, a_cnt_n;
  logic [CNTW-1:0]  b_cnt_q, b_cnt_n;
  op_e              op_q, op_n;
  op_e              next_op_q, next_op_n;
  logic             op_valid_q, op_valid_n;
  logic             chained_q, chained_n;
  logic             rv_q, rv_n;
  logic             err_q, err_n;

  logic             mul_start;
  logic             mul_done;
  logic [PW-1:0]    mul_product;

  logic [3:0]       digit;
  op_e              key_op;
  logic             k_num, k_op, k_eq, k_clr, k_arith;

  logic [RES_W:0]   sum;
  logic             add_ovf, mul_ovf;
  logic             calc_done, calc_ovf;
  logic [RES_W-1:0] calc_res;

  function automatic logic [OPW-1:0] append_digit(input logic [OPW-1:0] val,
                                                  input logic [3:0]     d);
    return val * OPW'(10) + OPW'(d);
  endfunction

  // Leading zeros do not consume a digit slot.
  function automatic logic [CNTW-1:0] next_count(input logic [CNTW-1:0] cnt,
                                                 input logic [OPW-1:0]  val,
                                                 input logic [3:0]      d);
    return (val == '0 && d == 4'd0) ? cnt : cnt + CNTW'(1);
  endfunction

  assign digit   = bus.num_val;
  assign key_op  = op_e'(bus.op_val);
  assign k_num   = bus.btn_pressed && bus.is_num && (bus.num_val <= 4'd9);
  assign k_op    = bus.btn_pressed && !bus.is_num && bus.is_op;
  assign k_eq    = bus.btn_pressed && !bus.is_num && !bus.is_op && bus.is_eq;
  assign k_clr   = k_op && (key_op == OP_CLR);
  assign k_arith = k_op && (key_op != OP_CLR);

  assign sum = (op_q == OP_SUB) ? {a_q[RES_W-1], a_q} - (RES_W+1)'(b_q)
                                : {a_q[RES_W-1], a_q} + (RES_W+1)'(b_q);
  assign add_ovf = sum[RES_W] ^ sum[RES_W-1];
  assign mul_ovf = mul_product[PW-1:RES_W-1] != {(OPW+1){mul_product[RES_W-1]}};

  assign calc_done = (op_q == OP_MUL) ? mul_done : 1'b1;
  assign calc_ovf  = (op_q == OP_MUL) ? mul_ovf : add_ovf;
  assign calc_res  = (op_q == OP_MUL) ? mul_product[RES_W-1:0] : sum[RES_W-1:0];

  calc_mul_seq #(
    .RES_W (RES_W),
    .OPW   (OPW)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_n    = state_q;
    a_n        = a_q;
    b_n        = b_q;
    a_cnt_n    = a_cnt_q;
    b_cnt_n    = b_cnt_q;
    disp_n     = disp_q;
    op_n       = op_q;
    next_op_n  = next_op_q;
    op_valid_n = op_valid_q;
    chained_n  = chained_q;
    err_n      = err_q;
    rv_n       = 1'b0;
    mul_start  = 1'b0;

    if (k_clr) begin
      state_n    = S_A;
      a_n        = '0;
      b_n        = '0;
      a_cnt_n    = '0;
      b_cnt_n    = '0;
      disp_n     = '0;
      op_n       = OP_ADD;
      next_op_n  = OP_ADD;
      op_valid_n = 1'b0;
      chained_n  = 1'b0;
      err_n      = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (k_num) begin
            if (a_cnt_q < CNTW'(MAX_DIGITS)) begin
              a_n     = RES_W'(append_digit(a_q[OPW-1:0], digit));
              a_cnt_n = next_count(a_cnt_q, a_q[OPW-1:0], digit);
              disp_n  = a_n;
            end
          end else if (k_arith) begin
            op_n       = key_op;
            op_valid_n = 1'b1;
            state_n    = S_OP;
          end
        end
        S_OP: begin
          if (k_num) begin
            b_n     = OPW'(digit);
            b_cnt_n = (digit != 4'd0) ? CNTW'(1) : '0;
            disp_n  = RES_W'(digit);
            state_n = S_B;
          end else if (k_arith) begin
            op_n = key_op;
          end
        end
        S_B: begin
          if (k_num) begin
            if (b_cnt_q < CNTW'(MAX_DIGITS)) begin
              b_n     = append_digit(b_q, digit);
              b_cnt_n = next_count(b_cnt_q, b_q, digit);
              disp_n  = RES_W'(b_n);
            end
          end else if (k_arith || k_eq) begin
            chained_n = k_arith;
            next_op_n = k_arith ? key_op : next_op_q;
            mul_start = (op_q == OP_MUL);
            state_n   = S_CALC;
          end
        end
        S_CALC: begin
          if (calc_done) begin
            if (calc_ovf) begin
              // Overflowed result is discarded; the display falls back to A.
              err_n      = 1'b1;
              disp_n     = a_q;
              op_valid_n = 1'b0;
              state_n    = S_ERR;
            end else begin
              a_n     = calc_res;
              disp_n  = calc_res;
              rv_n    = 1'b1;
              b_cnt_n = '0;
              if (chained_q) begin
                op_n       = next_op_q;
                op_valid_n = 1'b1;
                state_n    = S_OP;
              end else begin
                op_valid_n = 1'b0;
                state_n    = S_RES;
              end
            end
          end
        end
        S_RES: begin
          if (k_num) begin
            a_n     = RES_W'(digit);
            a_cnt_n = (digit != 4'd0) ? CNTW'(1) : '0;
            disp_n  = RES_W'(digit);
            state_n = S_A;
          end else if (k_arith) begin
            op_n       = key_op;
            op_valid_n = 1'b1;
            state_n    = S_OP;
          end
        end
        S_ERR: begin
          state_n = S_ERR;
        end
        default: begin
          state_n = S_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      disp_q     <= '0;
      op_q       <= OP_ADD;
      next_op_q  <= OP_ADD;
      op_valid_q <= 1'b0;
      chained_q  <= 1'b0;
      rv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      a_q        <= a_n;
      b_q        <= b_n;
      a_cnt_q    <= a_cnt_n;
      b_cnt_q    <= b_cnt_n;
      disp_q     <= disp_n;
      op_q       <= op_n;
      next_op_q  <= next_op_n;
      op_valid_q <= op_valid_n;
      chained_q  <= chained_n;
      rv_q       <= rv_n;
      err_q      <= err_n;
    end
  end

  assign bus.disp_val     = disp_q;
  assign bus.op_pending   = op_q;
  assign bus.op_valid     = op_valid_q;
  assign bus.busy         = (state_q == S_CALC);
  assign bus.result_valid = rv_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb/tb_calc_engine.sv - directed and random key sequences checked against a calculator model
module tb_calc_engine;

  localparam int OPW   = 10;
  localparam int RES_W = 24;
  localparam int MAXD  = 3;
  localparam longint RMAX = (longint'(1) << (RES_W - 1)) - 1;
  localparam longint RMIN = -(longint'(1) << (RES_W - 1));

  localparam int P_A = 0, P_OP = 1, P_B = 2, P_RES = 3, P_ERR = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  calc_if #(.RES_W(RES_W)) bus ();

  calc_engine #(
    .MAX_DIGITS (MAXD),
    .OPW        (OPW),
    .RES_W      (RES_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int     m_phase, m_digits, m_bdigits, m_op;
  longint m_a, m_b, m_disp;
  bit     m_opv, m_err;
  bit     inject_busy_key = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_A; m_digits = 0; m_bdigits = 0; m_op = 0;
    m_a = 0; m_b = 0; m_disp = 0; m_opv = 0; m_err = 0;
  endtask

  task automatic model_calc(input bit chain, input int nop);
    longint r;
    case (m_op)
      0:       r = m_a + m_b;
      1:       r = m_a - m_b;
      default: r = m_a * m_b;
    endcase
    if (r > RMAX || r < RMIN) begin
      m_phase = P_ERR; m_err = 1; m_disp = m_a; m_opv = 0;
    end else begin
      m_a = r; m_disp = r; m_bdigits = 0;
      if (chain) begin
        m_op = nop; m_opv = 1; m_phase = P_OP;
      end else begin
        m_opv = 0; m_phase = P_RES;
      end
    end
  endtask

  task automatic model_key(input bit nf, input bit of, input bit ef, input int nv, input int ov,
                           output bit calc, output bit is_mul);
    calc = 0;
    is_mul = 0;
    if (nf) begin
      if (nv <= 9) begin
        case (m_phase)
          P_A: if (m_digits < MAXD) begin
            m_a = m_a * 10 + nv;
            if (m_a != 0) m_digits++;
            m_disp = m_a;
          end
          P_OP: begin
            m_b = nv; m_bdigits = (nv != 0) ? 1 : 0; m_disp = nv; m_phase = P_B;
          end
          P_B: if (m_bdigits < MAXD) begin
            m_b = m_b * 10 + nv;
            if (m_b != 0) m_bdigits++;
            m_disp = m_b;
          end
          P_RES: begin
            m_a = nv; m_digits = (nv != 0) ? 1 : 0; m_disp = nv; m_phase = P_A;
          end
          default: ;
        endcase
      end
    end else if (of && ov == 3) begin
      model_reset();
    end else if (of) begin
      case (m_phase)
        P_A, P_RES: begin m_op = ov; m_opv = 1; m_phase = P_OP; end
        P_OP: m_op = ov;
        P_B: begin calc = 1; is_mul = (m_op == 2); model_calc(1, ov); end
        default: ;
      endcase
    end else if (ef && m_phase == P_B) begin
      calc = 1;
      is_mul = (m_op == 2);
      model_calc(0, 0);
    end
  endtask

  task automatic idle_inputs();
    bus.btn_pressed = 0; bus.is_num = 0; bus.is_op = 0; bus.is_eq = 0;
    bus.num_val = 4'd0; bus.op_val = 2'd0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_disp"}, $signed(bus.disp_val), m_disp);
    check({tag, "_op_valid"}, bus.op_valid, m_opv);
    if (m_opv) check({tag, "_op_pending"}, bus.op_pending, m_op);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_err"}, bus.err, m_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_disp"}, bus.disp_val, 0);
    check({tag, "_op_pending"}, bus.op_pending, 0);
    check({tag, "_op_valid"}, bus.op_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_rv"}, bus.result_valid, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  task automatic press(input bit nf, input bit of, input bit ef, input int nv, input int ov);
    bit calc, is_mul;
    int k, busy_n, lat;
    @(negedge clk);
    bus.btn_pressed = 1; bus.is_num = nf; bus.is_op = of; bus.is_eq = ef;
    bus.num_val = 4'(nv); bus.op_val = 2'(ov);
    @(negedge clk);
    idle_inputs();
    model_key(nf, of, ef, nv, ov, calc, is_mul);
    if (calc) begin
      k = 1;
      busy_n = 0;
      while (!(bus.result_valid || bus.err) && k < 64) begin
        if (bus.busy) busy_n++;
        idle_inputs();
        if (inject_busy_key && k == 1) begin
          bus.btn_pressed = 1; bus.is_num = 1; bus.num_val = 4'd7;
        end
        @(negedge clk);
        k++;
      end
      idle_inputs();
      lat = is_mul ? OPW + 2 : 2;
      check("latency", k, lat);
      check("busy_cycles", busy_n, lat - 1);
      if (!m_err) begin
        check("rv_pulse", bus.result_valid, 1);
        @(negedge clk);
        check("rv_once", bus.result_valid, 0);
      end
    end else begin
      check("no_rv", bus.result_valid, 0);
    end
    check_outputs("key");
  endtask

  task automatic dig(input int d);  press(1, 0, 0, d, 0); endtask
  task automatic opk(input int o);  press(0, 1, 0, 0, o); endtask
  task automatic eqk();             press(0, 0, 1, 0, 0); endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    dig(6); check("add_a", $signed(bus.disp_val), 6);
    opk(0); dig(1); check("add_b", $signed(bus.disp_val), 1);
    eqk();  check("add_res", $signed(bus.disp_val), 7);
    check("add_opv", bus.op_valid, 0);

    opk(3); dig(1); dig(2); opk(2); dig(3); dig(4); eqk();
    check("mul_408", $signed(bus.disp_val), 408);

    opk(3); dig(5); opk(1); dig(9); eqk();
    check("sub_bits", bus.disp_val, 64'(24'hFFFFFC));
    dig(3); check("after_res", $signed(bus.disp_val), 3);

    opk(3); dig(2); opk(0); dig(3); opk(2);
    check("chain_mid", $signed(bus.disp_val), 5);
    dig(4); eqk(); check("chain_end", $signed(bus.disp_val), 20);

    opk(3); dig(1); dig(2); dig(3); dig(4);
    check("max_digits", $signed(bus.disp_val), 123);
    opk(3); dig(0); dig(0); dig(7);
    check("lead_zero", $signed(bus.disp_val), 7);

    opk(3);
    dig(9); dig(9); dig(9); opk(2); dig(9); dig(9); dig(9); opk(2);
    check("ovf_mid", $signed(bus.disp_val), 998001);
    dig(9); dig(9); dig(9); eqk();
    check("ovf_err", bus.err, 1);
    check("ovf_hold", $signed(bus.disp_val), 998001);
    dig(5); check("err_digit", $signed(bus.disp_val), 998001);
    opk(3); check_reset_outputs("clear");

    dig(4);
    press(0, 0, 0, 5, 0);
    press(1, 0, 0, 12, 0);
    press(0, 0, 1, 0, 0);
    check("ignored", $signed(bus.disp_val), 4);
    opk(2); dig(3);
    inject_busy_key = 1'b1;
    eqk();
    inject_busy_key = 1'b0;
    check("busy_key", $signed(bus.disp_val), 12);

    opk(3); dig(1); dig(2); opk(2); dig(3); dig(4);
    @(negedge clk);
    bus.btn_pressed = 1; bus.is_eq = 1;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("busy_pre_reset", bus.busy, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    dig(1); dig(2); opk(2); dig(3); dig(4); eqk();
    check("mul_after_reset", $signed(bus.disp_val), 408);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (m_phase == P_ERR && r < 40) opk(3);
      else if (r < 50) dig($urandom_range(0, 9));
      else if (r < 53) press(1, 0, 0, $urandom_range(10, 15), 0);
      else if (r < 72) opk($urandom_range(0, 2));
      else if (r < 84) eqk();
      else if (r < 87) opk(3);
      else press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
